// File: rtl/hififo_fpc_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hififo_pkg
// Description : Shared constants and types for the HIFIFO from-PC request
//               engine: pointer and page-entry widths, block shift, PIO
//               register offsets and the issue FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hififo_pkg;

    localparam int PTR_W       = 19;   // block pointer width (pin/pout/stop/match)
    localparam int PAGE_LSB    = 14;   // ptr[18:14] = page index, ptr[13:0] = block
    localparam int PT_ENTRY_W  = 43;   // page base, byte address bits [63:21]
    localparam int PT_ENTRIES  = 32;
    localparam int BLOCK_SHIFT = 7;    // 128-byte blocks

    localparam logic [12:0] PIO_OFF_STOP  = 13'd0;
    localparam logic [12:0] PIO_OFF_MATCH = 13'd1;
    localparam logic [12:0] PIO_OFF_ERR   = 13'd2;
    localparam logic [12:0] PIO_OFF_PT    = 13'd32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REQ    = 2'd2
    } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/hififo_fpc_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : hififo_fpc_requester_if
// Description : Bus bundle between the fpc requester and its neighbours:
//               TX read-request handshake, RX completion notification and
//               fpc FIFO reservation / retire strobes.
//               master = requester side, slave = surrounding fabric.
// Revision    : 1.0 - initial release
// ============================================================================
interface hififo_fpc_requester_if;

    logic        tx_rr_valid;
    logic        tx_rr_ready;
    logic [63:0] tx_rr_addr;
    logic [7:0]  tx_rr_tag;

    logic        rx_cpl_valid;
    logic [7:0]  rx_cpl_tag;

    logic        fpc_rr_valid;
    logic        fpc_rr_ready;
    logic        fpc_retire_valid;
    logic [4:0]  fpc_retire_tag;

    modport master (
        output tx_rr_valid, tx_rr_addr, tx_rr_tag,
        output fpc_rr_ready, fpc_retire_valid, fpc_retire_tag,
        input  tx_rr_ready, rx_cpl_valid, rx_cpl_tag, fpc_rr_valid
    );

    modport slave (
        input  tx_rr_valid, tx_rr_addr, tx_rr_tag,
        input  fpc_rr_ready, fpc_retire_valid, fpc_retire_tag,
        output tx_rr_ready, rx_cpl_valid, rx_cpl_tag, fpc_rr_valid
    );

endinterface
`default_nettype wire

// File: rtl/hififo_fpc_requester_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hififo_tag_tracker
// Description : Completion map and in-order retire for the fpc requester.
//               Holds the NTAGS-bit done map and the retire pointer pout;
//               retires at most one head block per cycle.
// Ports       : clock, pci_reset_n      - clock, async active-low reset
//               pin                     - issue pointer from the top level
//               cpl_valid / cpl_tag     - completion notification
//               err_clear               - clears sticky error bits
//               pout                    - retire pointer
//               retire_valid/retire_tag - one-cycle retire strobe
//               err                     - {duplicate, spurious} sticky bits
// Config      : HIFIFO_FPC_ERRCHK_EN - drop and flag completions for tags
//               that are not outstanding or already completed.
// Revision    : 1.0 - initial release
// ============================================================================
module hififo_tag_tracker
    import hififo_pkg::*;
#(
    parameter int NTAGS = 32
) (
    input  wire              clock,
    input  wire              pci_reset_n,
    input  wire  [PTR_W-1:0] pin,
    input  wire              cpl_valid,
    input  wire  [7:0]       cpl_tag,
    input  wire              err_clear,
    output logic [PTR_W-1:0] pout,
    output logic             retire_valid,
    output logic [4:0]       retire_tag,
    output logic [1:0]       err
);

    localparam int TAG_W = $clog2(NTAGS);

    logic [NTAGS-1:0] r_done;
    logic [NTAGS-1:0] w_done_next;
    logic [PTR_W-1:0] r_pout;
    logic             r_retire_valid;
    logic [4:0]       r_retire_tag;
    logic [TAG_W-1:0] w_head;
    logic [TAG_W-1:0] w_cpl_idx;
    logic             w_retire;
    logic             w_accept;

    assign w_head    = r_pout[TAG_W-1:0];
    assign w_cpl_idx = cpl_tag[TAG_W-1:0];
    assign w_retire  = r_done[w_head] && (r_pout != pin);

`ifdef HIFIFO_FPC_ERRCHK_EN
    // A tag is outstanding when its distance from the head (mod NTAGS)
    // is below the number of blocks in flight.
    logic [TAG_W-1:0] w_offset;
    logic [PTR_W-1:0] w_inflight;
    logic             w_outstanding;
    logic             w_spurious;
    logic             w_duplicate;
    logic [1:0]       r_err;

    assign w_offset      = w_cpl_idx - w_head;
    assign w_inflight    = pin - r_pout;
    assign w_outstanding = (cpl_tag[7:TAG_W] == '0) &&
                           ({{(PTR_W-TAG_W){1'b0}}, w_offset} < w_inflight);
    assign w_spurious    = cpl_valid && !w_outstanding;
    assign w_duplicate   = cpl_valid && w_outstanding && r_done[w_cpl_idx];
    assign w_accept      = cpl_valid && w_outstanding && !r_done[w_cpl_idx];
    assign err           = r_err;

    always_ff @(posedge clock or negedge pci_reset_n) begin
        if (!pci_reset_n) begin
            r_err <= 2'b00;
        end else begin
            // A new error in the clearing cycle is still recorded.
            r_err <= (err_clear ? 2'b00 : r_err) | {w_duplicate, w_spurious};
        end
    end
`else
    logic w_unused_err;
    assign w_unused_err = ^cpl_tag[7:TAG_W] ^ err_clear;
    assign w_accept     = cpl_valid;
    assign err          = 2'b00;
`endif

    always_comb begin
        w_done_next = r_done;
        if (w_retire) begin
            w_done_next[w_head] = 1'b0;
        end
        if (w_accept) begin
            w_done_next[w_cpl_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge pci_reset_n) begin
        if (!pci_reset_n) begin
            r_done         <= '0;
            r_pout         <= '0;
            r_retire_valid <= 1'b0;
            r_retire_tag   <= 5'd0;
        end else begin
            r_done         <= w_done_next;
            r_retire_valid <= w_retire;
            if (w_retire) begin
                r_pout       <= r_pout + 1'b1;
                r_retire_tag <= 5'(w_head);
            end
        end
    end

    assign pout         = r_pout;
    assign retire_valid = r_retire_valid;
    assign retire_tag   = r_retire_tag;

endmodule
`default_nettype wire

// File: rtl/hififo_fpc_requester.sv
`default_nettype none
// ============================================================================
// Module      : hififo_fpc_requester
// Description : From-PC read-request engine. Turns PIO-programmed pointers
//               and a 32-entry page table into 128-byte PCIe read requests,
//               one tag per request, and retires completed blocks in order.
// Ports       : clock, pci_reset_n - clock, async active-low reset
//               pio_*              - PIO write/read access to stop, match,
//                                    error register and page table
//               interrupt          - pulse after pout reaches match
//               bus (master)       - tx_rr_*, rx_cpl_*, fpc_* signals
// Config      : HIFIFO_FPC_ERRCHK_EN - completion error checking (see
//               hififo_tag_tracker); error register reads 0 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module hififo_fpc_requester
    import hififo_pkg::*;
#(
    parameter int          NTAGS    = 32,
    parameter logic [12:0] PIO_BASE = 13'h0040
) (
    input  wire                     clock,
    input  wire                     pci_reset_n,
    input  wire                     pio_write_valid,
    input  wire                     pio_read_valid,
    input  wire  [12:0]             pio_address,
    input  wire  [63:0]             pio_write_data,
    output logic [63:0]             pio_read_data,
    output logic                    pio_read_done,
    output logic                    interrupt,
    hififo_fpc_requester_if.master  bus
);

    localparam int TAG_W = $clog2(NTAGS);

    issue_state_t          r_state;
    logic [PTR_W-1:0]      r_pin;
    logic [PTR_W-1:0]      r_stop;
    logic [PTR_W-1:0]      r_match;
    logic [PT_ENTRY_W-1:0] r_pt [PT_ENTRIES];
    logic                  r_tx_valid;
    logic [63:0]           r_tx_addr;
    logic [7:0]            r_tx_tag;
    logic                  r_rr_ready;
    logic [63:0]           r_rd_data;
    logic                  r_rd_done;
    logic                  r_irq;

    logic [PTR_W-1:0]      w_pout;
    logic                  w_retire_valid;
    logic [4:0]            w_retire_tag;
    logic [1:0]            w_err;
    logic [12:0]           w_off;
    logic                  w_wr_stop;
    logic                  w_wr_match;
    logic                  w_wr_err;
    logic                  w_wr_pt;
    logic [PTR_W-1:0]      w_inflight;
    logic                  w_can_issue;
    logic                  w_unused_bits;

    assign w_off         = pio_address - PIO_BASE;
    assign w_wr_stop     = pio_write_valid && (w_off == PIO_OFF_STOP);
    assign w_wr_match    = pio_write_valid && (w_off == PIO_OFF_MATCH);
    assign w_wr_err      = pio_write_valid && (w_off == PIO_OFF_ERR);
    assign w_wr_pt       = pio_write_valid && ((w_off & ~13'd31) == PIO_OFF_PT);
    assign w_unused_bits = ^pio_write_data[8:0];

    // Full/empty decided purely by the 19-bit pointer difference.
    assign w_inflight  = r_pin - w_pout;
    assign w_can_issue = (r_pin != r_stop) && (w_inflight < PTR_W'(NTAGS)) &&
                         bus.fpc_rr_valid;

    // Page table is deliberately not reset; software reloads it.
    always_ff @(posedge clock) begin
        if (w_wr_pt) begin
            r_pt[w_off[4:0]] <= pio_write_data[63:21];
        end
    end

    // Issue FSM: the LOOKUP cycle registers the page base into the request
    // address, so valid rises on entry to REQ and stays until accepted.
    always_ff @(posedge clock or negedge pci_reset_n) begin
        if (!pci_reset_n) begin
            r_state    <= ST_IDLE;
            r_pin      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_addr  <= '0;
            r_tx_tag   <= '0;
            r_rr_ready <= 1'b0;
        end else begin
            r_rr_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue) begin
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_tx_valid <= 1'b1;
                    r_tx_addr  <= {r_pt[r_pin[PTR_W-1:PAGE_LSB]],
                                   r_pin[PAGE_LSB-1:0], {BLOCK_SHIFT{1'b0}}};
                    r_tx_tag   <= 8'(r_pin[TAG_W-1:0]);
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.tx_rr_ready) begin
                        r_tx_valid <= 1'b0;
                        r_pin      <= r_pin + 1'b1;
                        r_rr_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // PIO registers, read port and match interrupt.
    always_ff @(posedge clock or negedge pci_reset_n) begin
        if (!pci_reset_n) begin
            r_stop    <= '0;
            r_match   <= '0;
            r_rd_data <= '0;
            r_rd_done <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_stop) begin
                r_stop <= pio_write_data[27:9];
            end
            if (w_wr_match) begin
                r_match <= pio_write_data[27:9];
            end
            r_rd_done <= pio_read_valid;
            if (pio_read_valid) begin
                case (w_off)
                    PIO_OFF_STOP:  r_rd_data <= 64'({w_pout, {BLOCK_SHIFT{1'b0}}});
                    PIO_OFF_MATCH: r_rd_data <= 64'({r_pin, {BLOCK_SHIFT{1'b0}}});
                    PIO_OFF_ERR:   r_rd_data <= 64'(w_err);
                    default:       r_rd_data <= '0;
                endcase
            end
            // retire_valid is high in the cycle pout has just advanced.
            r_irq <= w_retire_valid && (w_pout == r_match);
        end
    end

    hififo_tag_tracker #(
        .NTAGS (NTAGS)
    ) u_tag_tracker (
        .clock        (clock),
        .pci_reset_n  (pci_reset_n),
        .pin          (r_pin),
        .cpl_valid    (bus.rx_cpl_valid),
        .cpl_tag      (bus.rx_cpl_tag),
        .err_clear    (w_wr_err),
        .pout         (w_pout),
        .retire_valid (w_retire_valid),
        .retire_tag   (w_retire_tag),
        .err          (w_err)
    );

    assign bus.tx_rr_valid      = r_tx_valid;
    assign bus.tx_rr_addr       = r_tx_addr;
    assign bus.tx_rr_tag        = r_tx_tag;
    assign bus.fpc_rr_ready     = r_rr_ready;
    assign bus.fpc_retire_valid = w_retire_valid;
    assign bus.fpc_retire_tag   = w_retire_tag;
    assign pio_read_data        = r_rd_data;
    assign pio_read_done        = r_rd_done;
    assign interrupt            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hififo_fpc_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_hififo_fpc_requester
// Description : Directed self-checking bench for hififo_fpc_requester.
//               Honours HIFIFO_FPC_ERRCHK_EN for the error-register value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hififo_fpc_requester;

    localparam logic [12:0] BASE   = 13'h0040;
    localparam logic [63:0] PT0    = 64'h1_0000_0000;   // field 0x800
    localparam logic [63:0] PT1    = 64'h2_4680_0000;   // field 0x1234
`ifdef HIFIFO_FPC_ERRCHK_EN
    localparam logic [63:0] ERR_EXP = 64'd1;
`else
    localparam logic [63:0] ERR_EXP = 64'd0;
`endif

    logic        clock = 1'b0;
    logic        pci_reset_n = 1'b0;
    logic        pio_write_valid = 1'b0;
    logic        pio_read_valid = 1'b0;
    logic [12:0] pio_address = '0;
    logic [63:0] pio_write_data = '0;
    logic [63:0] pio_read_data;
    logic        pio_read_done;
    logic        interrupt;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt;
    logic [63:0] rd;

    hififo_fpc_requester_if bus ();

    hififo_fpc_requester #(
        .NTAGS    (32),
        .PIO_BASE (BASE)
    ) dut (
        .clock           (clock),
        .pci_reset_n     (pci_reset_n),
        .pio_write_valid (pio_write_valid),
        .pio_read_valid  (pio_read_valid),
        .pio_address     (pio_address),
        .pio_write_data  (pio_write_data),
        .pio_read_data   (pio_read_data),
        .pio_read_done   (pio_read_done),
        .interrupt       (interrupt),
        .bus             (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pio_wr(input logic [12:0] addr, input logic [63:0] data);
        pio_address     = addr;
        pio_write_data  = data;
        pio_write_valid = 1'b1;
        tick();
        pio_write_valid = 1'b0;
    endtask

    task automatic pio_rd(input logic [12:0] addr, output logic [63:0] data);
        pio_address    = addr;
        pio_read_valid = 1'b1;
        tick();
        pio_read_valid = 1'b0;
        check("pio_read_done", 64'(pio_read_done), 64'd1);
        data = pio_read_data;
    endtask

    task automatic complete(input logic [7:0] tag);
        bus.rx_cpl_valid = 1'b1;
        bus.rx_cpl_tag   = tag;
        tick();
        bus.rx_cpl_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.tx_rr_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_issue(input int budget);
        int n = 0;
        while (!bus.fpc_rr_ready && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic count_issues(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.fpc_rr_ready) c++;
        end
    endtask

    task automatic do_reset();
        pci_reset_n      = 1'b0;
        pio_write_valid  = 1'b0;
        pio_read_valid   = 1'b0;
        bus.rx_cpl_valid = 1'b0;
        bus.rx_cpl_tag   = '0;
        tick();
        tick();
        pci_reset_n = 1'b1;
        tick();
        pio_wr(BASE + 13'd32, PT0);
    endtask

    initial begin
        bus.tx_rr_ready  = 1'b1;
        bus.rx_cpl_valid = 1'b0;
        bus.rx_cpl_tag   = '0;
        bus.fpc_rr_valid = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_tx_valid", 64'(bus.tx_rr_valid), 64'd0);
        check("rst_tx_addr", bus.tx_rr_addr, 64'd0);
        check("rst_misc", 64'({bus.tx_rr_tag, bus.fpc_rr_ready, bus.fpc_retire_valid,
                               bus.fpc_retire_tag, interrupt, pio_read_done}), 64'd0);
        check("rst_rd_data", pio_read_data, 64'd0);
        pci_reset_n = 1'b1;
        tick();

        // Single request
        pio_wr(BASE + 13'd32, PT0);
        pio_wr(BASE + 13'd1, 64'h200);          // match = 1
        pio_rd(BASE + 13'd5, rd);
        check("unmapped_read", rd, 64'd0);
        pio_wr(BASE + 13'd0, 64'h200);          // stop = 1
        tick();
        check("lookup_no_valid", 64'(bus.tx_rr_valid), 64'd0);
        tick();
        check("issue_valid", 64'(bus.tx_rr_valid), 64'd1);
        check("issue_addr", bus.tx_rr_addr, 64'h1_0000_0000);
        check("issue_tag", 64'(bus.tx_rr_tag), 64'd0);
        tick();
        check("rr_ready_pulse", 64'({bus.fpc_rr_ready, bus.tx_rr_valid}), 64'b10);
        tick();
        check("rr_ready_one_cycle", 64'(bus.fpc_rr_ready), 64'd0);
        complete(8'd0);
        check("retire_not_yet", 64'(bus.fpc_retire_valid), 64'd0);
        tick();
        check("retire_tag0", 64'({bus.fpc_retire_valid, bus.fpc_retire_tag}), 64'b1_00000);
        tick();
        check("irq_pulse", 64'({interrupt, bus.fpc_retire_valid}), 64'b10);
        tick();
        check("irq_one_cycle", 64'(interrupt), 64'd0);
        pio_rd(BASE + 13'd0, rd);
        check("pout_read", rd, 64'h80);
        pio_rd(BASE + 13'd1, rd);
        check("pin_read", rd, 64'h80);

        // Out-of-order completions
        do_reset();
        pio_wr(BASE + 13'd0, 64'h800);          // stop = 4
        count_issues(30, cnt);
        check("ooo_issued", 64'(cnt), 64'd4);
        complete(8'd3);
        check("ooo_hold3", 64'(bus.fpc_retire_valid), 64'd0);
        complete(8'd2);
        check("ooo_hold2", 64'(bus.fpc_retire_valid), 64'd0);
        complete(8'd1);
        check("ooo_hold1", 64'(bus.fpc_retire_valid), 64'd0);
        complete(8'd0);
        check("ooo_hold0", 64'(bus.fpc_retire_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ooo_retire", 64'({bus.fpc_retire_valid, bus.fpc_retire_tag}),
                  64'({1'b1, 5'(i)}));
        end
        tick();
        check("ooo_done", 64'(bus.fpc_retire_valid), 64'd0);

        // Tag pool full
        do_reset();
        pio_wr(BASE + 13'd0, 64'h5000);         // stop = 40
        count_issues(200, cnt);
        check("pool_32", 64'(cnt), 64'd32);
        pio_rd(BASE + 13'd1, rd);
        check("pool_pin", rd, 64'h1000);
        complete(8'd0);
        wait_valid(20);
        check("pool_reissue_valid", 64'(bus.tx_rr_valid), 64'd1);
        check("pool_reissue_tag", 64'(bus.tx_rr_tag), 64'd0);
        check("pool_reissue_addr", bus.tx_rr_addr, 64'h1_0000_1000);
        count_issues(30, cnt);
        check("pool_refill_one", 64'(cnt), 64'd1);

        // Backpressure
        do_reset();
        bus.tx_rr_ready = 1'b0;
        pio_wr(BASE + 13'd0, 64'h200);          // stop = 1
        wait_valid(10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_tag", 64'({bus.tx_rr_valid, bus.tx_rr_tag}), 64'h100);
            check("bp_addr", bus.tx_rr_addr, 64'h1_0000_0000);
        end
        pio_rd(BASE + 13'd1, rd);
        check("bp_pin_held", rd, 64'd0);
        bus.tx_rr_ready = 1'b1;
        tick();
        check("bp_accept", 64'({bus.fpc_rr_ready, bus.tx_rr_valid}), 64'b10);

        // Page crossing: advance pin to 0x3FFF
        do_reset();
        pio_wr(BASE + 13'd33, PT1);
        pio_wr(BASE + 13'd0, 64'h7F_FE00);      // stop = 0x3FFF
        for (int k = 0; k < 32'h3FFF; k++) begin
            wait_issue(20);
            if (!bus.fpc_rr_ready) begin
                check("page_fill_issue", 64'(bus.fpc_rr_ready), 64'd1);
                break;
            end
            complete(8'(k % 32));
        end
        pio_rd(BASE + 13'd1, rd);
        check("page_pin", rd, 64'h1F_FF80);
        pio_wr(BASE + 13'd0, 64'h80_0200);      // stop = 0x4001
        wait_valid(10);
        check("page_last_addr", bus.tx_rr_addr, 64'h1_001F_FF80);
        check("page_last_tag", 64'(bus.tx_rr_tag), 64'd31);
        wait_issue(5);
        complete(8'd31);
        wait_valid(10);
        check("page_cross_valid", 64'(bus.tx_rr_valid), 64'd1);
        check("page_cross_addr", bus.tx_rr_addr, PT1);
        check("page_cross_tag", 64'(bus.tx_rr_tag), 64'd0);

        // Reset mid-flight
        do_reset();
        bus.tx_rr_ready = 1'b0;
        pio_wr(BASE + 13'd0, 64'h200);
        wait_valid(10);
        check("midrst_req", 64'(bus.tx_rr_valid), 64'd1);
        pci_reset_n = 1'b0;
        #1;
        check("midrst_drop", 64'(bus.tx_rr_valid), 64'd0);
        tick();
        pci_reset_n = 1'b1;
        bus.tx_rr_ready = 1'b1;
        tick();
        complete(8'd5);
        check("midrst_no_retire0", 64'(bus.fpc_retire_valid), 64'd0);
        tick();
        check("midrst_no_retire1", 64'(bus.fpc_retire_valid), 64'd0);
        pio_rd(BASE + 13'd2, rd);
        check("err_reg", rd, ERR_EXP);
        pio_wr(BASE + 13'd2, 64'd0);
        pio_rd(BASE + 13'd2, rd);
        check("err_cleared", rd, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
